// File: rtl/apb_master.sv
// APB initiator: decodes a single-cycle CPU request onto one PSEL line and runs IDLE/SETUP/ACCESS/DONE.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   transfer,
  input  logic                   write,
  input  logic [31:0]            addr,
  input  logic [31:0]            wdata,
  output logic [31:0]            rdata,
  output logic                   ready,
  output logic                   err,
  output logic [31:0]            PADDR,
  output logic                   PWRITE,
  output logic                   PENABLE,
  output logic [31:0]            PWDATA,
  output logic [NUM_SLV-1:0]     PSEL,
  input  logic [NUM_SLV*32-1:0]  PRDATA,
  input  logic [NUM_SLV-1:0]     PREADY
);

  localparam int IDXW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          r_state;
  logic [IDXW-1:0] r_idx;
  logic [31:0]     r_paddr;
  logic            r_pwrite;
  logic [31:0]     r_pwdata;
  logic [31:0]     r_rdata;
  logic            r_err;

  logic            w_hit;
  logic            w_active;
  logic            w_sel_rdy;
  logic [31:0]     w_sel_dat;

`ifdef APB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYC + 1);
  logic [CNTW-1:0] r_cnt;
  logic            w_tmo;
  // The count reaches TIMEOUT_CYC on this edge, i.e. after TIMEOUT_CYC ACCESS cycles.
  assign w_tmo = (r_cnt == CNTW'(TIMEOUT_CYC - 1));
`endif

  assign w_hit = (addr[31:16] == BASE_ADDR[31:16]) &&
                 ({1'b0, addr[15:12]} < 5'(NUM_SLV));

  assign w_active = (r_state == S_SETUP) || (r_state == S_ACCESS);

  // Only the selected slave's PREADY/PRDATA are ever looked at.
  always_comb begin
    w_sel_rdy = 1'b0;
    w_sel_dat = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == IDXW'(i)) begin
        w_sel_rdy = PREADY[i];
        w_sel_dat = PRDATA[i*32 +: 32];
      end
    end
  end

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      PSEL[i] = w_active && (r_idx == IDXW'(i));
    end
  end

  assign PENABLE = (r_state == S_ACCESS);
  assign PADDR   = r_paddr;
  assign PWRITE  = r_pwrite;
  assign PWDATA  = r_pwdata;
  assign rdata   = r_rdata;
  assign ready   = (r_state == S_DONE);
  assign err     = ready && r_err;

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_cnt    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (transfer) begin
            if (w_hit) begin
              r_idx    <= addr[12 +: IDXW];
              r_paddr  <= addr;
              r_pwrite <= write;
              r_pwdata <= wdata;
              r_err    <= 1'b0;
              r_state  <= S_SETUP;
            end else begin
              r_err    <= 1'b1;
              r_rdata  <= '0;
              r_state  <= S_DONE;
            end
          end
        end
        S_SETUP: begin
`ifdef APB_TIMEOUT_EN
          r_cnt   <= '0;
`endif
          r_state <= S_ACCESS;
        end
        S_ACCESS: begin
`ifdef APB_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
          // A PREADY on the limit cycle takes priority over the timeout.
          if (w_sel_rdy) begin
            r_rdata <= r_pwrite ? 32'h0 : w_sel_dat;
            r_state <= S_DONE;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_tmo) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_state <= S_DONE;
          end
`endif
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB initiator (bridge) between the RV32I multi-cycle CPU load/store path and the APB peripheral slaves (GPI, GPO, etc.).
- Takes a single-cycle CPU request and decodes the address to one PSEL line.
- Runs the IDLE/SETUP/ACCESS sequence, waits on the selected slave's PREADY, and returns read data with a one-cycle completion pulse.

Parameters:
- NUM_SLV, 4, number of APB slaves / PSEL lines (max 16).
- BASE_ADDR, 32'h1000_0000, start of the APB region.
- TIMEOUT_CYC, 16, ACCESS-phase cycle limit; used only with APB_TIMEOUT_EN.

Ports:
- PCLK  in  1  clock.
- PRESET  in  1  reset, synchronous, active-high.
- transfer  in  1  CPU request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read; sampled with transfer.
- addr  in  32  byte address; sampled with transfer.
- wdata  in  32  write data; sampled with transfer.
- rdata  out  32  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  error flag; valid while ready=1.
- PADDR  out  32  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB enable.
- PWDATA  out  32  APB write data.
- PSEL  out  NUM_SLV  one-hot slave select.
- PRDATA  in  NUM_SLV*32  concatenated slave read data; slave i at [32i+31:32i].
- PREADY  in  NUM_SLV  per-slave ready.

Behaviour:
- Clock and reset: one clock, PCLK. PRESET is synchronous and active-high.
- Reset values: state=IDLE; all outputs 0 (PSEL, PENABLE, PWRITE, PADDR, PWDATA, rdata, ready, err).
- Address decode:
  - hit when addr[31:16] == BASE_ADDR[31:16] and addr[15:12] < NUM_SLV.
  - idx = addr[15:12]; each slave gets a 4 KB window. PADDR carries the full address.
- Outputs: PSEL/PENABLE are decoded from registered state. PADDR/PWRITE/PWDATA come from registers captured in IDLE and stay stable through SETUP and ACCESS.
- IDLE:
  - transfer=1 with hit: capture addr/write/wdata and idx; go to SETUP.
  - transfer=1 with miss: go to DONE with err=1, rdata=0; no PSEL is asserted.
  - transfer=0: stay in IDLE.
- SETUP: PSEL[idx]=1, PENABLE=0 for exactly one cycle; go to ACCESS.
- ACCESS:
  - PSEL[idx]=1, PENABLE=1; hold while PREADY[idx]=0 (unbounded wait unless timeout is enabled).
  - On the edge where PREADY[idx]=1: for reads, latch PRDATA slice idx into rdata; for writes, set rdata=0. Go to DONE.
  - PREADY and PRDATA of unselected slaves are ignored.
- DONE:
  - ready=1 and err valid for exactly one cycle; PSEL=0, PENABLE=0; return to IDLE.
  - rdata holds its value until the next completion.
- Latency from transfer to ready:
  - zero-wait slave: 3 cycles.
  - GPI/GPO-style slave with registered PREADY: 4 cycles.
  - decode miss: 1 cycle.
- transfer asserted in any state other than IDLE is ignored and not queued; the CPU must wait for ready. transfer=1 in the DONE cycle is also ignored.
- Back-to-back: a new transfer is accepted in the IDLE cycle right after DONE. PSEL deasserts for at least one cycle between transactions.
- Reset mid-transaction: the next edge forces IDLE and drops PSEL/PENABLE; no ready pulse is produced.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined:
  - a counter clears on SETUP and increments each ACCESS cycle.
  - if it reaches TIMEOUT_CYC with PREADY[idx]=0, the block drops PSEL/PENABLE and goes to DONE with err=1, rdata=0.
  - a PREADY arriving in the same cycle the limit is hit wins (normal completion, err=0).
- Not defined: no counter; ACCESS waits indefinitely; err is set only on a decode miss.

Test Plan:
- Write, zero-wait slave 0: transfer with addr=0x1000_0000, write=1, wdata=0xA5 → SETUP PSEL=0001, PENABLE=0; next cycle PENABLE=1, PWDATA=0xA5; ready=1, err=0 at cycle 3.
- Read, slave 1 with PREADY one cycle into ACCESS, PRDATA1=0x0000_00C3: addr=0x1000_1004 → PSEL=0010, PADDR=0x1000_1004; ready at cycle 4 with rdata=0xC3; PRDATA0=0xFFFF_FFFF is ignored.
- Decode miss, addr=0x1000_5000 with NUM_SLV=4 → PSEL stays 0; ready=1, err=1, rdata=0 at cycle 1.
- Busy/back-to-back: second transfer pulsed during ACCESS is ignored (one transaction only). Transfer in the IDLE cycle after DONE → new SETUP, with one idle cycle of PSEL=0 between transactions.
- Reset mid-ACCESS: PRESET=1 for one cycle → PSEL=0, PENABLE=0, state IDLE next edge, no ready pulse; a following read completes normally.
- APB_TIMEOUT_EN, TIMEOUT_CYC=16, PREADY tied 0 → PENABLE high for exactly 16 cycles, then ready=1, err=1, rdata=0.
